// File: rtl/seg7_scan_ctrl.sv
// Scanned 8-digit common-anode seven-segment controller with shadow/active registers
// committed at frame boundaries. Define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  AN,
  output logic [6:0]  A2G,
  output logic        DP
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_TC    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  enable;
    logic [7:0]  dpmask;
  } regs_t;
  localparam regs_t REGS_RST = '{value: 32'h0, enable: 8'hFF, dpmask: 8'h00};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  regs_t         shadow, active;
  logic [PW-1:0] presc;
  logic [DW-1:0] digit;
  logic          slot_end, frame_end, write_hit;
  logic [3:0]    nib;
  logic [7:0]    an_sel;
  logic          suppress;

  assign slot_end   = (presc == PRE_TC);
  assign frame_end  = slot_end && (digit == DIG_LAST);
  assign frame_tick = frame_end;
  assign write_hit  = wr_en && (wr_addr != 2'd3);
  assign nib        = active.value[{digit, 2'b00} +: 4];
  assign an_sel     = ~(8'd1 << digit);

`ifdef SEG7_LZ_BLANK_EN
  // lz[d] is set when nibbles d..DIGITS-1 are all zero; digit 0 is never flagged.
  logic [7:0] lz;
  logic       zero_run;
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      zero_run = zero_run & (active.value[4*d +: 4] == 4'h0);
      lz[d]    = zero_run;
    end
  end
  assign suppress = lz[digit];
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      digit   <= '0;
      shadow  <= REGS_RST;
      active  <= REGS_RST;
      pending <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) digit <= (digit == DIG_LAST) ? '0 : digit + DW'(1);
      // Commit takes the pre-write shadow; a coincident write keeps pending set.
      if (frame_end) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (write_hit) begin
        pending <= 1'b1;
        case (wr_addr)
          2'd0:    shadow.value  <= wr_data;
          2'd1:    shadow.enable <= wr_data[7:0];
          default: shadow.dpmask <= wr_data[7:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      AN  <= 8'hFF;
      A2G <= 7'h7F;
      DP  <= 1'b1;
    end else if (presc < BLANK_END || !active.enable[digit]) begin
      AN  <= 8'hFF;
      A2G <= 7'h7F;
      DP  <= 1'b1;
    end else if (suppress) begin
      // Suppressed digit keeps its anode only to light a requested decimal point.
      AN  <= active.dpmask[digit] ? an_sel : 8'hFF;
      A2G <= 7'h7F;
      DP  <= ~active.dpmask[digit];
    end else begin
      AN  <= an_sel;
      A2G <= hex7(nib);
      DP  <= ~active.dpmask[digit];
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd0:    rd_data = shadow.value;
      2'd1:    rd_data = {24'b0, shadow.enable};
      2'd2:    rd_data = {24'b0, shadow.dpmask};
      default: rd_data = {31'b0, pending};
    endcase
  end
endmodule
